// File: rtl/alu_req_arbiter_if.sv
// Bus bundle between the requesters, the ALU units and alu_req_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface alu_req_arbiter_if #(
    parameter int Width = 16
);
    logic             Req0, Req1;
    logic [Width-1:0] A0, B0, A1, B1;
    logic [3:0]       FUN0, FUN1;
    logic             Ack0, Ack1;
    logic [Width-1:0] Result;
    logic             Result_Flag;
    logic             Busy;
    logic [Width-1:0] ALU_A, ALU_B;
    logic [1:0]       ALU_FUN;
    logic             Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable;
    logic [Width-1:0] Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT;
    logic             Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag;

    modport slave (
        input  Req0, Req1, A0, B0, A1, B1, FUN0, FUN1,
        input  Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT,
        input  Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag,
        output Ack0, Ack1, Result, Result_Flag, Busy,
        output ALU_A, ALU_B, ALU_FUN,
        output Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable
    );

    modport master (
        output Req0, Req1, A0, B0, A1, B1, FUN0, FUN1,
        output Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT,
        output Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag,
        input  Ack0, Ack1, Result, Result_Flag, Busy,
        input  ALU_A, ALU_B, ALU_FUN,
        input  Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// Two-port round-robin arbiter sequencing one operation at a time through
// the shared ALU units: IDLE -> ISSUE -> CAPTURE -> DONE, all outputs registered.
module alu_req_arbiter (
    input  logic               CLK,
    input  logic               RST,
    alu_req_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

    state_t     state;
    logic       ptr;
    logic       gnt_id;
    logic [1:0] unit_sel;
    logic       grant;
    logic       pick;
    logic [3:0] pick_fun;

    // NOTE: combinational outputs get a value on every path, so no latch is inferred.
    always_comb begin
        grant    = bus.Req0 | bus.Req1;
        pick     = (bus.Req0 && bus.Req1) ? ptr : bus.Req1;
        pick_fun = pick ? bus.FUN1 : bus.FUN0;
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state           <= IDLE;
            ptr             <= 1'b0;
            gnt_id          <= 1'b0;
            unit_sel        <= 2'b00;
            bus.Ack0        <= 1'b0;
            bus.Ack1        <= 1'b0;
            bus.Result      <= '0;
            bus.Result_Flag <= 1'b0;
            bus.Busy        <= 1'b0;
            bus.ALU_A       <= '0;
            bus.ALU_B       <= '0;
            bus.ALU_FUN     <= 2'b00;
            bus.Arith_Enable <= 1'b0;
            bus.Logic_Enable <= 1'b0;
            bus.CMP_Enable   <= 1'b0;
            bus.Shift_Enable <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        gnt_id           <= pick;
                        bus.ALU_A        <= pick ? bus.A1 : bus.A0;
                        bus.ALU_B        <= pick ? bus.B1 : bus.B0;
                        bus.ALU_FUN      <= pick_fun[1:0];
                        unit_sel         <= pick_fun[3:2];
                        bus.Arith_Enable <= (pick_fun[3:2] == 2'b00);
                        bus.Logic_Enable <= (pick_fun[3:2] == 2'b01);
                        bus.CMP_Enable   <= (pick_fun[3:2] == 2'b10);
                        bus.Shift_Enable <= (pick_fun[3:2] == 2'b11);
                        bus.Busy         <= 1'b1;
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.Arith_Enable <= 1'b0;
                    bus.Logic_Enable <= 1'b0;
                    bus.CMP_Enable   <= 1'b0;
                    bus.Shift_Enable <= 1'b0;
                    state            <= CAPTURE;
                end
                CAPTURE: begin
                    // Units registered their result at the end of ISSUE, so it is stable here.
                    case (unit_sel)
                        2'b00: begin bus.Result <= bus.Arith_OUT; bus.Result_Flag <= bus.Arith_Flag; end
                        2'b01: begin bus.Result <= bus.Logic_OUT; bus.Result_Flag <= bus.Logic_Flag; end
                        2'b10: begin bus.Result <= bus.CMP_OUT;   bus.Result_Flag <= bus.CMP_Flag;   end
                        2'b11: begin bus.Result <= bus.Shift_OUT; bus.Result_Flag <= bus.Shift_Flag; end
                    endcase
                    bus.Ack0 <= ~gnt_id;
                    bus.Ack1 <= gnt_id;
                    state    <= DONE;
                end
                DONE: begin
                    bus.Ack0 <= 1'b0;
                    bus.Ack1 <= 1'b0;
                    bus.Busy <= 1'b0;
                    ptr      <= ~gnt_id;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
